// File: rtl/rca_cpu_reg_config_unit_if.sv
// Config-instruction handshake between issue and the RCA CPU register
// config unit. The issue side is the master; the config unit is the slave.
interface rca_cpu_reg_config_unit_if #(
  parameter int unsigned SELW = 2,
  parameter int unsigned PSW  = 3
);
  logic            valid;
  logic            ready;
  logic [SELW-1:0] rca_sel;
  logic            src_dest;
  logic [PSW-1:0]  port_sel;
  logic [4:0]      reg_addr;
  logic            done;

  modport master (
    output valid, rca_sel, src_dest, port_sel, reg_addr,
    input  ready, done
  );

  modport slave (
    input  valid, rca_sel, src_dest, port_sel, reg_addr,
    output ready, done
  );
endinterface

// File: rtl/rca_cpu_reg_config_unit.sv
// Execution-side store for RCA CPU register mappings. Config instructions
// update per-RCA source/dest register tables, but only once the target RCA
// has no in-flight use instructions. decode_config layout: source port p at
// [5*p +: 5], dest port w at [5*(NUM_READ_PORTS+w) +: 5].
module rca_cpu_reg_config_unit #(
  parameter int unsigned NUM_RCAS        = 4,
  parameter int unsigned NUM_READ_PORTS  = 5,
  parameter int unsigned NUM_WRITE_PORTS = 2,
  parameter int unsigned MAX_INFLIGHT    = 7,
  localparam int unsigned SELW = $clog2(NUM_RCAS),
  localparam int unsigned PSW  = $clog2(NUM_READ_PORTS),
  localparam int unsigned CW   = $clog2(MAX_INFLIGHT + 1),
  localparam int unsigned CFGW = 5 * (NUM_READ_PORTS + NUM_WRITE_PORTS)
) (
  input  logic            clk,
  input  logic            rst_n,
  rca_cpu_reg_config_unit_if.slave cfg,
  input  logic            use_issue,
  input  logic [SELW-1:0] use_issue_sel,
  input  logic            use_complete,
  input  logic [SELW-1:0] use_complete_sel,
  input  logic [SELW-1:0] decode_rca_sel,
  output logic [CFGW-1:0] decode_config,
  output logic            use_stall
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  logic [1:0]      state, state_nxt;
  logic [SELW-1:0] lat_sel;
  logic            lat_dst;
  logic [PSW-1:0]  lat_port;
  logic [4:0]      lat_addr;

  logic [4:0]    src_tab [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]    dst_tab [NUM_RCAS][NUM_WRITE_PORTS];
  logic [CW-1:0] inflight     [NUM_RCAS];
  logic [CW-1:0] inflight_nxt [NUM_RCAS];

  logic [NUM_RCAS-1:0] issue_hit, complete_hit;
  logic cfg_sel_free, lat_drained;

  // Next in-flight counts: issue/complete decoded per RCA, saturating at both ends
  always_comb begin
    issue_hit    = '0;
    complete_hit = '0;
    for (int unsigned r = 0; r < NUM_RCAS; r++) begin
      issue_hit[r]    = use_issue && (use_issue_sel == SELW'(r));
      complete_hit[r] = use_complete && (use_complete_sel == SELW'(r));
      inflight_nxt[r] = inflight[r];
      if (issue_hit[r] && !complete_hit[r] && inflight[r] != CW'(MAX_INFLIGHT))
        inflight_nxt[r] = inflight[r] + CW'(1);
      else if (complete_hit[r] && !issue_hit[r] && inflight[r] != '0)
        inflight_nxt[r] = inflight[r] - CW'(1);
    end
  end

  // Drain status of the incoming and the latched target RCA
  always_comb begin
    cfg_sel_free = 1'b0;
    lat_drained  = 1'b0;
    for (int unsigned r = 0; r < NUM_RCAS; r++) begin
      if (cfg.rca_sel == SELW'(r))
        cfg_sel_free = (inflight[r] == '0) && !issue_hit[r];
      // Looking at the post-update count lets WRITE follow the last completion directly
      if (lat_sel == SELW'(r))
        lat_drained = (inflight_nxt[r] == '0);
    end
  end

  // Config FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg.valid) state_nxt = cfg_sel_free ? WRITE : DRAIN;
      DRAIN:   if (lat_drained) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and latched config instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_sel  <= '0;
      lat_dst  <= 1'b0;
      lat_port <= '0;
      lat_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cfg.valid) begin
        lat_sel  <= cfg.rca_sel;
        lat_dst  <= cfg.src_dest;
        lat_port <= cfg.port_sel;
        lat_addr <= cfg.reg_addr;
      end
    end
  end

  // Table update in WRITE; out-of-range ports match no entry, so the write is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_RCAS; r++) begin
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++) src_tab[r][p] <= '0;
        for (int unsigned w = 0; w < NUM_WRITE_PORTS; w++) dst_tab[r][w] <= '0;
      end
    end else if (state == WRITE) begin
      for (int unsigned r = 0; r < NUM_RCAS; r++) begin
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++)
          if (lat_sel == SELW'(r) && !lat_dst && lat_port == PSW'(p))
            src_tab[r][p] <= lat_addr;
        for (int unsigned w = 0; w < NUM_WRITE_PORTS; w++)
          if (lat_sel == SELW'(r) && lat_dst && lat_port == PSW'(w))
            dst_tab[r][w] <= lat_addr;
      end
    end
  end

  // In-flight counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_RCAS; r++) inflight[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_RCAS; r++) inflight[r] <= inflight_nxt[r];
    end
  end

  // Decode-stage view of the selected RCA's tables (no same-cycle write bypass)
  always_comb begin
    decode_config = '0;
    for (int unsigned r = 0; r < NUM_RCAS; r++) begin
      if (decode_rca_sel == SELW'(r)) begin
        for (int unsigned p = 0; p < NUM_READ_PORTS; p++)
          decode_config[5*p +: 5] = src_tab[r][p];
        for (int unsigned w = 0; w < NUM_WRITE_PORTS; w++)
          decode_config[5*(NUM_READ_PORTS+w) +: 5] = dst_tab[r][w];
      end
    end
  end

  assign cfg.ready = (state == IDLE);
  assign cfg.done  = (state == WRITE);
  assign use_stall = (state != IDLE) && (decode_rca_sel == lat_sel);

endmodule

// File: tb/tb_rca_cpu_reg_config_unit.sv
// Directed bench for the RCA CPU register config unit.
module tb_rca_cpu_reg_config_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        use_issue, use_complete;
  logic [1:0]  use_issue_sel, use_complete_sel, decode_rca_sel;
  logic [34:0] decode_config;
  logic        use_stall;

  int checks = 0;
  int failures = 0;
  logic [34:0] exp_cfg [4];
  int unsigned mcnt [4];

  rca_cpu_reg_config_unit_if #(.SELW(2), .PSW(3)) cfg_if ();

  rca_cpu_reg_config_unit #(
    .NUM_RCAS(4), .NUM_READ_PORTS(5), .NUM_WRITE_PORTS(2), .MAX_INFLIGHT(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg_if),
    .use_issue(use_issue), .use_issue_sel(use_issue_sel),
    .use_complete(use_complete), .use_complete_sel(use_complete_sel),
    .decode_rca_sel(decode_rca_sel), .decode_config(decode_config),
    .use_stall(use_stall)
  );

  always #5 clk = ~clk;

  // Illegal use traffic is flagged against a reference count of in-flight uses
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 4; r++) mcnt[r] <= 0;
    end else begin
      if (use_complete)
        assert (mcnt[use_complete_sel] != 0) else $error("use_complete at count 0 on rca %0d", use_complete_sel);
      if (use_issue)
        assert (mcnt[use_issue_sel] != 7) else $error("use_issue at max inflight on rca %0d", use_issue_sel);
      for (int r = 0; r < 4; r++) begin
        if (use_issue && use_issue_sel == 2'(r) && !(use_complete && use_complete_sel == 2'(r)) && mcnt[r] != 7)
          mcnt[r] <= mcnt[r] + 1;
        else if (use_complete && use_complete_sel == 2'(r) && !(use_issue && use_issue_sel == 2'(r)) && mcnt[r] != 0)
          mcnt[r] <= mcnt[r] - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    cfg_if.valid = 1'b0;
    use_issue    = 1'b0;
    use_complete = 1'b0;
  endtask

  task automatic drive_cfg(input logic [1:0] sel, input logic dst, input logic [2:0] port, input logic [4:0] addr);
    cfg_if.valid    = 1'b1;
    cfg_if.rca_sel  = sel;
    cfg_if.src_dest = dst;
    cfg_if.port_sel = port;
    cfg_if.reg_addr = addr;
  endtask

  task automatic test_reset();
    quiet();
    drive_cfg(2'd0, 1'b0, 3'd0, 5'd0);
    cfg_if.valid = 1'b0;
    use_issue_sel = 2'd0; use_complete_sel = 2'd0; decode_rca_sel = 2'd0;
    for (int r = 0; r < 4; r++) exp_cfg[r] = '0;
    #3;
    for (int s = 0; s < 4; s++) begin
      decode_rca_sel = 2'(s); #1;
      checks++; if (decode_config !== 35'd0) begin failures++; $display("FAIL reset_decode_cfg sel=%0d: got %h want 0", s, decode_config); end
    end
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", cfg_if.ready); end
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", cfg_if.done); end
    checks++; if (use_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", use_stall); end
    tick();
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL reset_ready_held: got %b want 1", cfg_if.ready); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_src_write();
    tick(); drive_cfg(2'd1, 1'b0, 3'd2, 5'd11); decode_rca_sel = 2'd1; #1;
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL src_accept_ready: got %b want 1", cfg_if.ready); end
    tick(); quiet(); #1;
    checks++; if (cfg_if.done !== 1'b1) begin failures++; $display("FAIL src_done: got %b want 1", cfg_if.done); end
    checks++; if (cfg_if.ready !== 1'b0) begin failures++; $display("FAIL src_write_ready: got %b want 0", cfg_if.ready); end
    checks++; if (use_stall !== 1'b1) begin failures++; $display("FAIL src_write_stall: got %b want 1", use_stall); end
    checks++; if (decode_config !== exp_cfg[1]) begin failures++; $display("FAIL src_no_bypass: got %h want %h", decode_config, exp_cfg[1]); end
    tick(); #1;
    exp_cfg[1][14:10] = 5'd11;
    checks++; if (decode_config !== exp_cfg[1]) begin failures++; $display("FAIL src_visible: got %h want %h", decode_config, exp_cfg[1]); end
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL src_done_pulse: got %b want 0", cfg_if.done); end
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL src_ready_back: got %b want 1", cfg_if.ready); end
  endtask

  task automatic test_drain();
    tick(); use_issue = 1'b1; use_issue_sel = 2'd0;
    tick();
    tick(); use_issue = 1'b0; drive_cfg(2'd0, 1'b1, 3'd1, 5'd7); decode_rca_sel = 2'd0; #1;
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL drain_accept_ready: got %b want 1", cfg_if.ready); end
    tick(); quiet(); #1;
    checks++; if (cfg_if.ready !== 1'b0) begin failures++; $display("FAIL drain_ready: got %b want 0", cfg_if.ready); end
    checks++; if (use_stall !== 1'b1) begin failures++; $display("FAIL drain_stall_same: got %b want 1", use_stall); end
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL drain_done_early: got %b want 0", cfg_if.done); end
    decode_rca_sel = 2'd2; #1;
    checks++; if (use_stall !== 1'b0) begin failures++; $display("FAIL drain_stall_other: got %b want 0", use_stall); end
    decode_rca_sel = 2'd0;
    tick(); use_complete = 1'b1; use_complete_sel = 2'd0; #1;
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL drain_done_c1: got %b want 0", cfg_if.done); end
    tick(); #1;
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL drain_done_c2: got %b want 0", cfg_if.done); end
    tick(); use_complete = 1'b0; #1;
    checks++; if (cfg_if.done !== 1'b1) begin failures++; $display("FAIL drain_done: got %b want 1", cfg_if.done); end
    tick(); #1;
    exp_cfg[0][34:30] = 5'd7;
    checks++; if (decode_config !== exp_cfg[0]) begin failures++; $display("FAIL drain_dest_value: got %h want %h", decode_config, exp_cfg[0]); end
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL drain_ready_back: got %b want 1", cfg_if.ready); end
  endtask

  task automatic test_same_cycle();
    tick(); use_issue = 1'b1; use_issue_sel = 2'd3;
    tick(); use_complete = 1'b1; use_complete_sel = 2'd3;
    tick(); quiet(); drive_cfg(2'd3, 1'b0, 3'd0, 5'd20); decode_rca_sel = 2'd3; #1;
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL same_accept_ready: got %b want 1", cfg_if.ready); end
    tick(); quiet(); #1;
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL same_drains: got %b want 0", cfg_if.done); end
    checks++; if (use_stall !== 1'b1) begin failures++; $display("FAIL same_stall: got %b want 1", use_stall); end
    tick(); #1;
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL same_still_drain: got %b want 0", cfg_if.done); end
    tick(); use_complete = 1'b1; use_complete_sel = 2'd3; #1;
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL same_done_c: got %b want 0", cfg_if.done); end
    tick(); use_complete = 1'b0; #1;
    checks++; if (cfg_if.done !== 1'b1) begin failures++; $display("FAIL same_done: got %b want 1", cfg_if.done); end
    tick(); #1;
    exp_cfg[3][4:0] = 5'd20;
    checks++; if (decode_config !== exp_cfg[3]) begin failures++; $display("FAIL same_value: got %h want %h", decode_config, exp_cfg[3]); end
  endtask

  task automatic test_cross_sel();
    tick(); use_issue = 1'b1; use_issue_sel = 2'd1;
    tick(); use_issue_sel = 2'd2; use_complete = 1'b1; use_complete_sel = 2'd1;
    tick(); quiet(); drive_cfg(2'd1, 1'b0, 3'd1, 5'd5); #1;
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL cross_accept_ready: got %b want 1", cfg_if.ready); end
    tick(); quiet(); #1;
    checks++; if (cfg_if.done !== 1'b1) begin failures++; $display("FAIL cross_no_drain: got %b want 1", cfg_if.done); end
    tick(); drive_cfg(2'd2, 1'b0, 3'd3, 5'd6); decode_rca_sel = 2'd2; #1;
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL cross_ready2: got %b want 1", cfg_if.ready); end
    tick(); quiet(); #1;
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL cross_drain2: got %b want 0", cfg_if.done); end
    checks++; if (use_stall !== 1'b1) begin failures++; $display("FAIL cross_stall2: got %b want 1", use_stall); end
    tick(); use_complete = 1'b1; use_complete_sel = 2'd2; #1;
    tick(); use_complete = 1'b0; #1;
    checks++; if (cfg_if.done !== 1'b1) begin failures++; $display("FAIL cross_done2: got %b want 1", cfg_if.done); end
    tick(); #1;
    exp_cfg[1][9:5] = 5'd5;
    exp_cfg[2][19:15] = 5'd6;
    checks++; if (decode_config !== exp_cfg[2]) begin failures++; $display("FAIL cross_value2: got %h want %h", decode_config, exp_cfg[2]); end
    decode_rca_sel = 2'd1; #1;
    checks++; if (decode_config !== exp_cfg[1]) begin failures++; $display("FAIL cross_value1: got %h want %h", decode_config, exp_cfg[1]); end
  endtask

  task automatic test_out_of_range();
    tick(); drive_cfg(2'd2, 1'b0, 3'd5, 5'd31); #1;
    tick(); quiet(); #1;
    checks++; if (cfg_if.done !== 1'b1) begin failures++; $display("FAIL oor_src_done: got %b want 1", cfg_if.done); end
    tick(); drive_cfg(2'd2, 1'b1, 3'd2, 5'd30); #1;
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL oor_dst_ready: got %b want 1", cfg_if.ready); end
    tick(); quiet(); #1;
    checks++; if (cfg_if.done !== 1'b1) begin failures++; $display("FAIL oor_dst_done: got %b want 1", cfg_if.done); end
    tick();
    for (int s = 0; s < 4; s++) begin
      decode_rca_sel = 2'(s); #1;
      checks++; if (decode_config !== exp_cfg[s]) begin failures++; $display("FAIL oor_tables sel=%0d: got %h want %h", s, decode_config, exp_cfg[s]); end
    end
  endtask

  task automatic test_back_to_back();
    tick(); drive_cfg(2'd0, 1'b0, 3'd4, 5'd9); decode_rca_sel = 2'd0; #1;
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_n: got %b want 1", cfg_if.ready); end
    tick(); #1;
    checks++; if (cfg_if.done !== 1'b1) begin failures++; $display("FAIL b2b_done1: got %b want 1", cfg_if.done); end
    checks++; if (cfg_if.ready !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %b want 0", cfg_if.ready); end
    tick(); drive_cfg(2'd0, 1'b1, 3'd0, 5'd3); #1;
    exp_cfg[0][24:20] = 5'd9;
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_n2: got %b want 1", cfg_if.ready); end
    checks++; if (decode_config !== exp_cfg[0]) begin failures++; $display("FAIL b2b_value1: got %h want %h", decode_config, exp_cfg[0]); end
    tick(); quiet(); #1;
    checks++; if (cfg_if.done !== 1'b1) begin failures++; $display("FAIL b2b_done2: got %b want 1", cfg_if.done); end
    tick(); #1;
    exp_cfg[0][29:25] = 5'd3;
    checks++; if (decode_config !== exp_cfg[0]) begin failures++; $display("FAIL b2b_value2: got %h want %h", decode_config, exp_cfg[0]); end
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL b2b_done_end: got %b want 0", cfg_if.done); end
  endtask

  task automatic test_reset_in_drain();
    tick(); use_issue = 1'b1; use_issue_sel = 2'd0;
    tick(); use_issue = 1'b0; drive_cfg(2'd0, 1'b0, 3'd0, 5'd15); decode_rca_sel = 2'd0;
    tick(); quiet(); #1;
    checks++; if (cfg_if.ready !== 1'b0) begin failures++; $display("FAIL rst_drain_entered: got %b want 0", cfg_if.ready); end
    #1 rst_n = 1'b0; #1;
    checks++; if (cfg_if.ready !== 1'b1) begin failures++; $display("FAIL rst_drain_ready: got %b want 1", cfg_if.ready); end
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL rst_drain_done: got %b want 0", cfg_if.done); end
    checks++; if (use_stall !== 1'b0) begin failures++; $display("FAIL rst_drain_stall: got %b want 0", use_stall); end
    for (int s = 0; s < 4; s++) begin
      decode_rca_sel = 2'(s); #0;
      checks++; if (decode_config !== 35'd0) begin failures++; $display("FAIL rst_drain_cleared sel=%0d: got %h want 0", s, decode_config); end
    end
    decode_rca_sel = 2'd0;
    #2 rst_n = 1'b1;
    tick(); #1;
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL rst_drain_no_done1: got %b want 0", cfg_if.done); end
    tick(); #1;
    checks++; if (cfg_if.done !== 1'b0) begin failures++; $display("FAIL rst_drain_no_done2: got %b want 0", cfg_if.done); end
    checks++; if (decode_config !== 35'd0) begin failures++; $display("FAIL rst_drain_no_write: got %h want 0", decode_config); end
  endtask

  initial begin
    test_reset();
    test_src_write();
    test_drain();
    test_same_cycle();
    test_cross_sel();
    test_out_of_range();
    test_back_to_back();
    test_reset_in_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
